// File: rtl/divider_repsub.sv
`default_nettype none
// ============================================================================
// Module      : divider_repsub
// Description : 16-bit by 8-bit unsigned divider using repeated subtraction.
//               The divider takes one cycle per quotient unit plus one
//               terminating cycle. A zero divisor takes a single-cycle DZ path
//               that flags the condition.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_repsub (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a_in,
    input  logic [7:0]  b_in,
    output logic        ready,
    output logic [15:0] q,
    output logic [7:0]  rem,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DZ   = 2'd1,
        S_OP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] w_q,     w_d;      // working remainder
    logic [7:0]  dvs_q,   dvs_d;    // captured divisor
    logic [15:0] quo_q,   quo_d;    // quotient accumulator
    logic        dz_q,    dz_d;     // divide-by-zero flag

    logic [15:0] dvs_ext;
    logic        w_ge_d;
    logic [15:0] w_minus_d;

    // Full 16-bit compare and subtract against the zero-extended divisor
    assign dvs_ext   = {8'h00, dvs_q};
    assign w_ge_d    = (w_q >= dvs_ext);
    assign w_minus_d = w_q - dvs_ext;

    // Next-state and datapath selection; every register holds unless updated
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvs_d   = b_in;
                    w_d     = a_in;
                    quo_d   = 16'h0000;
                    dz_d    = 1'b0;
                    state_d = (b_in == 8'h00) ? S_DZ : S_OP;
                end
            end
            S_OP: begin
                if (w_ge_d) begin
                    w_d   = w_minus_d;
                    quo_d = quo_q + 16'h0001;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DZ: begin
                // The captured dividend's low byte becomes the reported remainder
                quo_d   = 16'hFFFF;
                w_d     = {8'h00, w_q[7:0]};
                dz_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and data registers with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            w_q     <= 16'h0000;
            dvs_q   <= 8'h00;
            quo_q   <= 16'h0000;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            dz_q    <= dz_d;
        end
    end

    // Outputs come straight from registers
    assign ready       = (state_q == S_IDLE);
    assign q           = quo_q;
    assign rem         = w_q[7:0];
    assign div_by_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_repsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_repsub
// Description : Self-checking bench for divider_repsub. Expected results are
//               pushed to a scoreboard queue on each accepted start and popped
//               when the divider returns to ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_repsub;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] a_in;
    logic [7:0]  b_in;
    logic        ready;
    logic [15:0] q;
    logic [7:0]  rem;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   busy_cycles;

    divider_repsub dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .ready       (ready),
        .q           (q),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count cycles with ready low, sampled mid-cycle
    always @(negedge clock) begin
        if (ready !== 1'b1) busy_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse and push the reference result
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'h00) begin
            e.q   = 16'hFFFF;
            e.r   = a[7:0];
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = a / {8'h00, b};
            e.r   = 8'(a % {8'h00, b});
            e.dz  = 1'b0;
            e.lat = int'(e.q) + 1;
        end
        sb.push_back(e);
        @(negedge clock);
        #1;
        busy_cycles = 0;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, ready}, 32'd0);
    endtask

    // Wait (bounded) for ready and compare against the scoreboard head
    task automatic finish_op(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (ready !== 1'b1 && n < 70000) begin
            @(negedge clock);
            n++;
        end
        #1;
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_q"},   {16'd0, q},             {16'd0, e.q});
            check({tag, "_rem"}, {24'd0, rem},           {24'd0, e.r});
            check({tag, "_dz"},  {31'd0, div_by_zero},   {31'd0, e.dz});
            check({tag, "_lat"}, busy_cycles,            e.lat);
        end
    endtask

    initial begin
        exp_t        dropped;
        logic [15:0] hold_q;
        logic [7:0]  hold_r;
        checks      = 0;
        errors      = 0;
        busy_cycles = 0;
        reset = 1'b1;
        start = 1'b1;
        a_in  = 16'd9;
        b_in  = 8'd3;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", {31'd0, ready},       32'd1);
        check("rst_q",     {16'd0, q},           32'd0);
        check("rst_rem",   {24'd0, rem},         32'd0);
        check("rst_dz",    {31'd0, div_by_zero}, 32'd0);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Directed cases with their spec-given values
        issue(16'd100, 8'd7);
        finish_op("d100_7");
        check("d100_7_qconst", {16'd0, q}, 32'd14);
        check("d100_7_rconst", {24'd0, rem}, 32'd2);

        issue(16'd5, 8'd9);
        finish_op("d5_9");

        issue(16'h04D2, 8'd0);
        finish_op("dz");
        check("dz_qconst", {16'd0, q}, 32'hFFFF);
        check("dz_rconst", {24'd0, rem}, 32'hD2);

        issue(16'd50, 8'd5);
        finish_op("d50_5_after_dz");

        // Results hold in idle while inputs wander
        hold_q = q;
        hold_r = rem;
        a_in = 16'h1234;
        b_in = 8'h56;
        repeat (5) @(posedge clock);
        #1;
        check("idle_hold_q",  {16'd0, q},           {16'd0, hold_q});
        check("idle_hold_r",  {24'd0, rem},         {24'd0, hold_r});
        check("idle_hold_dz", {31'd0, div_by_zero}, 32'd0);

        issue(16'd65535, 8'd255);
        finish_op("d65535_255");

        issue(16'd255, 8'd255);
        finish_op("d255_255");

        // Inputs ignored while busy
        issue(16'd200, 8'd1);
        repeat (10) @(posedge clock);
        #1;
        start = 1'b1;
        a_in  = 16'd7;
        b_in  = 8'd3;
        repeat (3) @(posedge clock);
        #1;
        start = 1'b0;
        a_in  = 16'd0;
        b_in  = 8'd0;
        finish_op("ignore_busy");

        // Asynchronous reset mid-operation
        issue(16'd200, 8'd1);
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready},       32'd1);
        check("abort_q",     {16'd0, q},           32'd0);
        check("abort_rem",   {24'd0, rem},         32'd0);
        check("abort_dz",    {31'd0, div_by_zero}, 32'd0);
        if (sb.size() > 0) dropped = sb.pop_front();
        start = 1'b1;
        @(posedge clock);
        #1;
        check("start_in_reset", {31'd0, ready}, 32'd1);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        issue(16'd50, 8'd5);
        finish_op("d50_5_after_rst");

        // Longest case
        issue(16'd65535, 8'd1);
        finish_op("d65535_1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
